// File: rtl/matmul_apb_slave.sv
// APB3 slave front-end for the matmul accelerator: decodes transfers into CTRL
// accesses, operand/scratchpad buffer strobes and core start commands.
module matmul_apb_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int SP_NTARGETS = 4,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [BUS_WIDTH-1:0]  pwdata,
    input  logic [MAX_DIM-1:0]    pstrb,
    output logic [BUS_WIDTH-1:0]  prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  busy,
    output logic                  start,
    output logic [BUS_WIDTH-1:0]  ctrl,
    output logic                  buf_wr_en,
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [BUS_WIDTH-1:0]  buf_wdata,
    output logic [MAX_DIM-1:0]    buf_strb,
    input  logic [BUS_WIDTH-1:0]  buf_rdata,
    input  logic                  core_done
);

    localparam int SUB_ADDRESS_FACTOR = (MAX_DIM > 2) ? 16 : 4;
    localparam int MAX_ADDR = (16 + 4 * SP_NTARGETS) * SUB_ADDRESS_FACTOR;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR_L = ADDR_WIDTH'(MAX_ADDR);

    typedef enum logic [1:0] {IDLE, ACCESS, RUN} state_t;

    state_t state;
    logic   setup_busy;   // the current transfer's setup phase saw busy=1

    logic setup, access, addr_ok, is_ctrl, is_buf, xfer;

    assign setup   = psel & ~penable;
    assign access  = psel & penable & pready;
    assign addr_ok = (paddr <= MAX_ADDR_L);
    assign is_ctrl = (paddr == '0);
    assign is_buf  = ~is_ctrl & addr_ok;
    // A transfer with side effects: properly set up while idle, legal address
    assign xfer    = access & (state == ACCESS) & ~busy & ~setup_busy & addr_ok;

    assign buf_addr  = paddr;
    assign buf_wdata = pwdata;
    assign buf_strb  = pstrb;

    // Combinational outputs are forced low during reset so a master still
    // driving psel cannot leak strobes through an asserted rst.
    assign pslverr   = ~rst & ((psel & busy) | (access & (~addr_ok | setup_busy)));
    assign buf_rd_en = ~rst & setup & ~busy & (state == IDLE) & ~pwrite & is_buf;
    assign buf_wr_en = ~rst & xfer & pwrite & is_buf;
    assign prdata    = (~rst & xfer & ~pwrite) ? (is_ctrl ? ctrl : buf_rdata) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            setup_busy <= 1'b0;
            pready     <= 1'b0;
            busy       <= 1'b0;
            start      <= 1'b0;
            ctrl       <= '0;
        end else begin
            start  <= 1'b0;
            pready <= setup;
            if (setup)
                setup_busy <= busy;
            case (state)
                IDLE: begin
                    if (setup)
                        state <= ACCESS;
                end
                ACCESS: begin
                    state <= IDLE;
                    if (xfer & pwrite & is_ctrl) begin
                        ctrl <= {pwdata[BUS_WIDTH-1:1], 1'b0};
                        if (pwdata[0]) begin
                            start <= 1'b1;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // a done coinciding with our own start pulse is stale
                    if (core_done & ~start) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed bench for matmul_apb_slave: vector table for single transfers plus
// hand sequences for start/busy, reset and back-to-back corners.
module tb_matmul_apb_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [15:0] paddr, pwdata;
    logic [1:0]  pstrb;
    logic [15:0] prdata;
    logic        pready, pslverr, busy, start;
    logic [15:0] ctrl;
    logic        buf_wr_en, buf_rd_en;
    logic [15:0] buf_addr, buf_wdata;
    logic [1:0]  buf_strb;
    logic [15:0] buf_rdata;
    logic        core_done;

    int nchecks = 0;
    int nerrors = 0;

    matmul_apb_slave dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .busy(busy), .start(start),
        .ctrl(ctrl), .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_strb(buf_strb),
        .buf_rdata(buf_rdata), .core_done(core_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // One APB transfer starting at posedge+1; ends at posedge+1 after the
    // access edge with psel still high (caller drops it or chains another).
    task automatic apb(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] rd,
                       output logic s_rd, output logic s_err, output logic s_rdy,
                       output logic a_rdy, output logic a_err, output logic a_wr,
                       output logic a_rd, output logic [15:0] a_prd,
                       output logic [15:0] a_wd);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = 2'b11;
        #4;
        s_rd = buf_rd_en; s_err = pslverr; s_rdy = pready;
        @(posedge clk); #1;
        penable = 1'b1; buf_rdata = rd;
        #4;
        a_rdy = pready; a_err = pslverr; a_wr = buf_wr_en; a_rd = buf_rd_en;
        a_prd = prdata; a_wd = buf_wdata;
        @(posedge clk); #1;
        penable = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr, wd, rd;
        logic        err, wen, ren;
        logic [15:0] prd;
    } vec_t;

    vec_t v[10];
    logic s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd;
    logic [15:0] a_prd, a_wd;

    initial begin
        // MAX_ADDR = (16+4*4)*4 = 128
        v[0] = '{1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
        v[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF};
        v[2] = '{1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        v[3] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h5A5A};
        v[4] = '{1'b1, 16'h0080, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
        v[5] = '{1'b0, 16'h0080, 16'h0000, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h1111};
        v[6] = '{1'b1, 16'h0084, 16'hCAFE, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        v[7] = '{1'b0, 16'h0084, 16'h0000, 16'hDEAD, 1'b1, 1'b0, 1'b0, 16'h0000};
        v[8] = '{1'b1, 16'h0081, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        v[9] = '{1'b1, 16'h0000, 16'hA5A4, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; buf_rdata = '0; core_done = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_pready", {15'd0, pready}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_start", {15'd0, start}, 16'd0);
        chk("rst_ctrl", ctrl, 16'h0000);
        chk("rst_prdata", prdata, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        next_cycle();

        // single transfers from the table
        for (int i = 0; i < 10; i++) begin
            apb(v[i].wr, v[i].addr, v[i].wd, v[i].rd,
                s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
            psel = 1'b0;
            chk($sformatf("v%0d_setup_pready", i), {15'd0, s_rdy}, 16'd0);
            chk($sformatf("v%0d_setup_err", i), {15'd0, s_err}, 16'd0);
            chk($sformatf("v%0d_rd_en", i), {15'd0, s_rd}, {15'd0, v[i].ren});
            chk($sformatf("v%0d_pready", i), {15'd0, a_rdy}, 16'd1);
            chk($sformatf("v%0d_pslverr", i), {15'd0, a_err}, {15'd0, v[i].err});
            chk($sformatf("v%0d_wr_en", i), {15'd0, a_wr}, {15'd0, v[i].wen});
            chk($sformatf("v%0d_prdata", i), a_prd, v[i].prd);
            chk($sformatf("v%0d_wdata", i), a_wd, v[i].wd);
            #4;
            chk($sformatf("v%0d_wr_en_gone", i), {15'd0, buf_wr_en}, 16'd0);
            chk($sformatf("v%0d_start", i), {15'd0, start}, 16'd0);
            next_cycle();
        end
        chk("ctrl_no_start", ctrl, 16'hA5A4);
        chk("busy_no_start", {15'd0, busy}, 16'd0);

        // back-to-back: write then read with psel held high
        apb(1'b1, 16'h0030, 16'h4321, 16'h0000,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        chk("b2b0_pready", {15'd0, a_rdy}, 16'd1);
        chk("b2b0_wr_en", {15'd0, a_wr}, 16'd1);
        apb(1'b0, 16'h0030, 16'h0000, 16'h4321,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        chk("b2b1_setup_pready", {15'd0, s_rdy}, 16'd0);
        chk("b2b1_rd_en", {15'd0, s_rd}, 16'd1);
        chk("b2b1_pready", {15'd0, a_rdy}, 16'd1);
        chk("b2b1_prdata", a_prd, 16'h4321);
        next_cycle();

        // core_done while idle is ignored
        core_done = 1'b1; next_cycle(); core_done = 1'b0; #4;
        chk("done_idle_busy", {15'd0, busy}, 16'd0);
        next_cycle();

        // start: setup T, access T+1, start and busy at T+2; done in T+2 ignored
        apb(1'b1, 16'h0000, 16'h0001, 16'h0000,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        chk("start_acc_err", {15'd0, a_err}, 16'd0);
        chk("start_acc_wr_en", {15'd0, a_wr}, 16'd0);
        core_done = 1'b1;
        #4;
        chk("start_pulse", {15'd0, start}, 16'd1);
        chk("start_busy", {15'd0, busy}, 16'd1);
        chk("start_ctrl", ctrl, 16'h0000);
        next_cycle();
        core_done = 1'b0;
        #4;
        chk("start_one_cycle", {15'd0, start}, 16'd0);
        chk("busy_held", {15'd0, busy}, 16'd1);
        next_cycle();

        // accesses while busy: errors, pready still on time, no strobes
        apb(1'b1, 16'h0020, 16'h9999, 16'h0000,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        chk("busy_wr_setup_err", {15'd0, s_err}, 16'd1);
        chk("busy_wr_setup_rdy", {15'd0, s_rdy}, 16'd0);
        chk("busy_wr_pready", {15'd0, a_rdy}, 16'd1);
        chk("busy_wr_err", {15'd0, a_err}, 16'd1);
        chk("busy_wr_en", {15'd0, a_wr}, 16'd0);
        next_cycle();
        apb(1'b0, 16'h0000, 16'h0000, 16'h0000,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        chk("busy_rd_ctrl_err", {15'd0, a_err}, 16'd1);
        chk("busy_rd_ctrl_prdata", a_prd, 16'h0000);
        next_cycle();

        // core_done in cycle N: busy falls at N+1
        core_done = 1'b1;
        #4;
        chk("done_cycle_busy", {15'd0, busy}, 16'd1);
        next_cycle();
        core_done = 1'b0;
        #4;
        chk("done_busy_fall", {15'd0, busy}, 16'd0);
        next_cycle();
        apb(1'b0, 16'h0000, 16'h0000, 16'hFFFF,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        chk("post_run_ctrl", a_prd, 16'h0000);
        chk("post_run_err", {15'd0, a_err}, 16'd0);
        next_cycle();

        // reset in the access phase of a buffer write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010; pwdata = 16'h5555;
        next_cycle();
        penable = 1'b1;
        #1;
        chk("pre_rst_wr_en", {15'd0, buf_wr_en}, 16'd1);
        rst = 1'b1;
        #1;
        chk("rst_acc_pready", {15'd0, pready}, 16'd0);
        chk("rst_acc_wr_en", {15'd0, buf_wr_en}, 16'd0);
        next_cycle();
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        next_cycle();
        apb(1'b1, 16'h0010, 16'h6666, 16'h0000,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        chk("after_rst_pready", {15'd0, a_rdy}, 16'd1);
        chk("after_rst_wr_en", {15'd0, a_wr}, 16'd1);
        next_cycle();

        // reset during RUN
        apb(1'b1, 16'h0000, 16'h0003, 16'h0000,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        next_cycle();
        #1;
        chk("run_busy", {15'd0, busy}, 16'd1);
        chk("run_ctrl", ctrl, 16'h0002);
        rst = 1'b1;
        #1;
        chk("rst_run_busy", {15'd0, busy}, 16'd0);
        chk("rst_run_ctrl", ctrl, 16'h0000);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        apb(1'b1, 16'h0040, 16'h7E7E, 16'h0000,
            s_rd, s_err, s_rdy, a_rdy, a_err, a_wr, a_rd, a_prd, a_wd);
        psel = 1'b0;
        chk("after_run_rst_err", {15'd0, a_err}, 16'd0);
        chk("after_run_rst_wr_en", {15'd0, a_wr}, 16'd1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/matmul_apb_slave.md
Name: matmul_apb_slave

Overview:
- APB3 slave front-end of the matmul accelerator; sits between the APB bus and the matmul core / operand buffers.
- Decodes APB transfers into control-register accesses, operand/scratchpad buffer writes and reads, and core start commands.
- Generates the pready, pslverr and busy signals seen on matmul_intf.

Parameters:
DATA_WIDTH, 8, width of one matrix element
BUS_WIDTH, 16, APB data width; MAX_DIM = BUS_WIDTH/DATA_WIDTH
ADDR_WIDTH, 16, APB address width
SP_NTARGETS, 4, number of scratchpad targets
(derived) SUB_ADDRESS_FACTOR = 16 if MAX_DIM>2 else 4; MAX_ADDR = (16+4*SP_NTARGETS)*SUB_ADDRESS_FACTOR

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB direction, 1 = write
paddr  in  ADDR_WIDTH  APB address
pwdata  in  BUS_WIDTH  APB write data
pstrb  in  MAX_DIM  byte strobes, forwarded to buffers
prdata  out  BUS_WIDTH  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
busy  out  1  core operating
start  out  1  one-cycle core start pulse
ctrl  out  BUS_WIDTH  control register contents (bit0 excluded, always read 0)
buf_wr_en  out  1  operand/scratchpad write strobe
buf_rd_en  out  1  operand/scratchpad read strobe
buf_addr  out  ADDR_WIDTH  paddr passed through
buf_wdata  out  BUS_WIDTH  pwdata passed through
buf_strb  out  MAX_DIM  pstrb passed through
buf_rdata  in  BUS_WIDTH  buffer read data, 1-cycle latency
core_done  in  1  one-cycle pulse, operation finished

Behaviour:
- Reset values (async on rst): prdata=0, pready=0, pslverr=0, busy=0, start=0, ctrl=0, buf_wr_en=0, buf_rd_en=0.
- FSM states: IDLE, ACCESS, RUN.
- IDLE -> ACCESS on psel & !penable (setup phase).
- pready is registered and rises exactly one cycle after psel rises; no wait states.
- ACCESS (psel & penable & pready): transfer completes, then return to IDLE.
- Back-to-back transfers: psel held high, new setup on the following cycle; pready must rise again one cycle after each new setup.
- Address 0 = control register (CTRL): bit0 is START (write-1, self-clearing, reads 0); other bits are stored in ctrl. All other addresses within 0..MAX_ADDR go to the buffers.
- Buffer reads:
  - buf_rd_en is driven combinationally in the setup cycle.
  - buf_rdata is valid in the access cycle and muxed onto prdata.
- Buffer writes: buf_wr_en is asserted for one cycle in the access cycle.
- Error conditions:
  - pslverr is asserted combinationally whenever psel & busy (any phase); the access is ignored and pready still responds one cycle after setup.
  - pslverr is also asserted in the access cycle when paddr > MAX_ADDR; no buffer strobe is issued and prdata = 0.
- Start sequence:
  - A write to address 0 with pwdata[0]=1 is accepted at access cycle T+1 (setup at T).
  - start pulses at T+2; busy rises at T+2; FSM goes to RUN.
- RUN:
  - busy is held high.
  - Every APB access gets pslverr and has no side effects.
  - core_done in cycle N: busy falls at N+1, FSM returns to IDLE.
- Simultaneous events:
  - core_done in the same cycle as the start pulse is ignored.
  - core_done while not busy is ignored.
  - psel in the cycle busy falls is treated as not-busy from the next cycle.
- Reset mid-transfer: all outputs return to reset values immediately and the FSM goes to IDLE. A transfer in flight is dropped; the master must restart it.
- START write with pwdata[0]=0: ctrl is updated, no start pulse, busy unchanged.

Test Plan:
1. Reset, then APB write 0x1234 to addr 0x10 -> pready=1 one cycle after psel rise; buf_wr_en one cycle with buf_wdata=0x1234; pslverr=0.
2. Read addr 0x10 with buf_rdata=0xBEEF -> buf_rd_en in setup cycle; prdata=0xBEEF while pready=1.
3. Write 0x0001 to addr 0 at setup T -> start=1 at T+2 and busy=1 from T+2; a read of CTRL afterwards gives pslverr=1. Pulse core_done -> busy=0 next cycle; CTRL then reads 0x0000.
4. While busy, write addr 0x20 -> pslverr=1 throughout psel, pready one cycle after setup, no buf_wr_en.
5. Write to MAX_ADDR+4 -> pslverr=1 in the access cycle, no strobes. Read the same address -> prdata=0, pslverr=1.
6. Assert rst during the access phase of a buffer write and during RUN -> pready, busy and strobes are 0 in the same cycle; the next write completes normally.
